// File: rtl/parity_frame_chk_if.sv
// -----------------------------------------------------------------------------
// parity_frame_chk_if
//
// Purpose:
//   Bundles the beat stream and the report outputs of parity_frame_chk into a
//   single interface. Clock and reset are kept as plain ports on the checker.
//
// Configuration macro:
//   PARITY_STATS_EN - adds stats_clr, ok_cnt and err_cnt to the bundle.
//
// Signals (direction seen from the checker, i.e. the slave modport):
//   data_in    in  [DATA_W-1:0]  beat data, every bit enters parity
//   valid      in                beat qualifier, a frame is a contiguous run
//   mode       in                0 = even, 1 = odd, sampled on the first beat
//   abort      in                discard the frame currently being collected
//   frame_done out               one-cycle report strobe
//   parity_ok  out               frame XOR matched the latched mode
//   parity_err out               frame_done & ~parity_ok
//   len_err    out               frame was longer than MAX_BEATS
//   frame_len  out [LEN_W-1:0]   accepted beats, saturating at MAX_BEATS
//   stats_clr  in                (macro only) clear both statistics counters
//   ok_cnt     out [STAT_W-1:0]  (macro only) clean-frame counter
//   err_cnt    out [STAT_W-1:0]  (macro only) failed-frame counter
// -----------------------------------------------------------------------------
interface parity_frame_chk_if #(
    parameter int DATA_W    = 8,
    parameter int MAX_BEATS = 16,
    parameter int LEN_W     = $clog2(MAX_BEATS + 1),
    parameter int STAT_W    = 16
);

    logic [DATA_W-1:0] data_in;
    logic              valid;
    logic              mode;
    logic              abort;

    logic              frame_done;
    logic              parity_ok;
    logic              parity_err;
    logic              len_err;
    logic [LEN_W-1:0]  frame_len;

`ifdef PARITY_STATS_EN
    logic              stats_clr;
    logic [STAT_W-1:0] ok_cnt;
    logic [STAT_W-1:0] err_cnt;

    // Stream source / report consumer.
    modport master (
        output data_in,
        output valid,
        output mode,
        output abort,
        output stats_clr,
        input  frame_done,
        input  parity_ok,
        input  parity_err,
        input  len_err,
        input  frame_len,
        input  ok_cnt,
        input  err_cnt
    );

    // The checker itself.
    modport slave (
        input  data_in,
        input  valid,
        input  mode,
        input  abort,
        input  stats_clr,
        output frame_done,
        output parity_ok,
        output parity_err,
        output len_err,
        output frame_len,
        output ok_cnt,
        output err_cnt
    );
`else
    // Stream source / report consumer.
    modport master (
        output data_in,
        output valid,
        output mode,
        output abort,
        input  frame_done,
        input  parity_ok,
        input  parity_err,
        input  len_err,
        input  frame_len
    );

    // The checker itself.
    modport slave (
        input  data_in,
        input  valid,
        input  mode,
        input  abort,
        output frame_done,
        output parity_ok,
        output parity_err,
        output len_err,
        output frame_len
    );
`endif

endinterface : parity_frame_chk_if

// File: rtl/parity_frame_chk.sv
// -----------------------------------------------------------------------------
// parity_frame_chk
//
// Purpose:
//   Frame parity checker for wide serial links. The XOR of every bit of every
//   accepted beat is accumulated over a contiguous run of valid beats. The
//   first idle cycle after a frame produces a single-cycle registered report:
//   parity match against the mode latched on the first beat, the frame length
//   (saturating at MAX_BEATS) and a length-overflow flag.
//
// Configuration macro:
//   PARITY_STATS_EN - when defined, two saturating statistics counters
//                     (ok_cnt / err_cnt) and their clear input are built.
//                     When undefined they are absent; everything else is
//                     identical.
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous, active-low reset
//   bus    slave modport of parity_frame_chk_if (beat stream in, report out)
//
// Parameters:
//   DATA_W     bits per beat
//   MAX_BEATS  legal frame length limit (>= 1)
//   LEN_W      width of frame_len, must hold MAX_BEATS
//   STAT_W     statistics counter width (used with PARITY_STATS_EN)
// -----------------------------------------------------------------------------
module parity_frame_chk #(
    parameter int DATA_W    = 8,
    parameter int MAX_BEATS = 16,
    parameter int LEN_W     = $clog2(MAX_BEATS + 1),
    parameter int STAT_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    parity_frame_chk_if.slave   bus
);

    // -------------------------------------------------------------------------
    // Elaboration-time parameter sanity
    // -------------------------------------------------------------------------
    if (DATA_W < 1) begin : g_bad_data_w
        $error("parity_frame_chk: DATA_W must be at least 1");
    end
    if (MAX_BEATS < 1) begin : g_bad_max_beats
        $error("parity_frame_chk: MAX_BEATS must be at least 1");
    end
    if (LEN_W < $clog2(MAX_BEATS + 1)) begin : g_bad_len_w
        $error("parity_frame_chk: LEN_W too narrow to hold MAX_BEATS");
    end
    if (STAT_W < 1) begin : g_bad_stat_w
        $error("parity_frame_chk: STAT_W must be at least 1");
    end

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BEATS);
    localparam logic [LEN_W-1:0] ONE_LEN = LEN_W'(1);

    // -------------------------------------------------------------------------
    // Per-beat parity: XOR of all data bits of the current beat.
    // Written as a chain; synthesis rebalances it into a tree.
    // -------------------------------------------------------------------------
    logic [DATA_W:0] xor_chain;
    logic            beat_par;

    assign xor_chain[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_beat_xor
            assign xor_chain[gi+1] = xor_chain[gi] ^ bus.data_in[gi];
        end
    endgenerate

    assign beat_par = xor_chain[DATA_W];

    // -------------------------------------------------------------------------
    // Frame FSM
    // -------------------------------------------------------------------------
    typedef enum logic {
        S_IDLE = 1'b0,
        S_ACC  = 1'b1
    } state_t;

    state_t            state_q,  state_d;
    logic              acc_q,    acc_d;     // running XOR of the frame
    logic              mode_q,   mode_d;    // mode latched on the first beat
    logic [LEN_W-1:0]  cnt_q,    cnt_d;     // beats seen, held at MAX_BEATS
    logic              ovf_q,    ovf_d;     // a beat beyond MAX_BEATS arrived

    // Registered report
    logic              done_q,   done_d;
    logic              ok_q,     ok_d;
    logic              perr_q,   perr_d;
    logic              lerr_q,   lerr_d;
    logic [LEN_W-1:0]  len_q,    len_d;

    always_comb begin
        // Hold frame context by default; the report is a pulse so it
        // defaults to all-zero every cycle.
        state_d = state_q;
        acc_d   = acc_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        ok_d    = 1'b0;
        perr_d  = 1'b0;
        lerr_d  = 1'b0;
        len_d   = '0;

        case (state_q)
            S_IDLE: begin
                // abort in IDLE simply suppresses the start of a frame.
                if (bus.valid && !bus.abort) begin
                    state_d = S_ACC;
                    acc_d   = beat_par;
                    mode_d  = bus.mode;
                    cnt_d   = ONE_LEN;
                    ovf_d   = 1'b0;
                end
            end

            S_ACC: begin
                if (bus.abort) begin
                    // Discard without a report; context is left stale
                    // because the next first beat overwrites all of it.
                    state_d = S_IDLE;
                end else if (bus.valid) begin
                    // Parity keeps accumulating even past the length limit.
                    acc_d = acc_q ^ beat_par;
                    if (cnt_q == MAX_LEN) begin
                        ovf_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + ONE_LEN;
                    end
                end else begin
                    // First idle cycle closes the frame.
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    ok_d    = (acc_q == mode_q);
                    perr_d  = (acc_q != mode_q);
                    lerr_d  = ovf_q;
                    len_d   = cnt_q;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            acc_q   <= 1'b0;
            mode_q  <= 1'b0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            ok_q    <= 1'b0;
            perr_q  <= 1'b0;
            lerr_q  <= 1'b0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            ok_q    <= ok_d;
            perr_q  <= perr_d;
            lerr_q  <= lerr_d;
            len_q   <= len_d;
        end
    end

    assign bus.frame_done = done_q;
    assign bus.parity_ok  = ok_q;
    assign bus.parity_err = perr_q;
    assign bus.len_err    = lerr_q;
    assign bus.frame_len  = len_q;

`ifdef PARITY_STATS_EN
    // -------------------------------------------------------------------------
    // Statistics: counted on the same edge that registers the report, so the
    // counters already include a frame while its frame_done is high.
    // -------------------------------------------------------------------------
    logic [STAT_W-1:0] ok_cnt_q,  ok_cnt_d;
    logic [STAT_W-1:0] err_cnt_q, err_cnt_d;
    logic              clean_frame;

    // A frame is only "clean" when parity matched and length was legal.
    assign clean_frame = ok_d & ~lerr_d;

    always_comb begin
        ok_cnt_d  = ok_cnt_q;
        err_cnt_d = err_cnt_q;

        if (bus.stats_clr) begin
            // Clear wins over an increment on the same edge.
            ok_cnt_d  = '0;
            err_cnt_d = '0;
        end else if (done_d) begin
            if (clean_frame) begin
                if (ok_cnt_q != '1) begin
                    ok_cnt_d = ok_cnt_q + STAT_W'(1);
                end
            end else begin
                if (err_cnt_q != '1) begin
                    err_cnt_d = err_cnt_q + STAT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ok_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            ok_cnt_q  <= ok_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.ok_cnt  = ok_cnt_q;
    assign bus.err_cnt = err_cnt_q;
`endif

endmodule : parity_frame_chk

// File: tb/tb_parity_frame_chk.sv
// -----------------------------------------------------------------------------
// tb_parity_frame_chk
//
// Directed frames with hand-computed reports. The stimulus process pushes the
// expected report when it drives the idle cycle that closes a frame; a
// separate monitor pops and compares whenever frame_done is seen, and checks
// that report outputs are zero in every other cycle.
// -----------------------------------------------------------------------------
module tb_parity_frame_chk;

    localparam int DATA_W    = 8;
    localparam int MAX_BEATS = 4;
    localparam int LEN_W     = $clog2(MAX_BEATS + 1);
    localparam int STAT_W    = 2;
    localparam int STAT_MAX  = (1 << STAT_W) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    parity_frame_chk_if #(
        .DATA_W    (DATA_W),
        .MAX_BEATS (MAX_BEATS),
        .LEN_W     (LEN_W),
        .STAT_W    (STAT_W)
    ) bus ();

    parity_frame_chk #(
        .DATA_W    (DATA_W),
        .MAX_BEATS (MAX_BEATS),
        .LEN_W     (LEN_W),
        .STAT_W    (STAT_W)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic             ok;
        logic             lerr;
        logic [LEN_W-1:0] len;
    } rpt_t;

    rpt_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   ok_exp  = 0;
    int   err_exp = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push(input logic ok, input logic lerr, input int len);
        rpt_t r;
        r.ok   = ok;
        r.lerr = lerr;
        r.len  = LEN_W'(len);
        exp_q.push_back(r);
    endtask

    // One stimulus cycle, driven on the falling edge.
    task automatic cyc(input logic v, input logic [DATA_W-1:0] d, input logic m, input logic a);
        @(negedge clk);
        bus.valid   = v;
        bus.data_in = d;
        bus.mode    = m;
        bus.abort   = a;
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_done"}, 32'(bus.frame_done), 32'd0);
        chk({name, "_rpt"},  32'({bus.parity_ok, bus.parity_err, bus.len_err, bus.frame_len}), 32'd0);
`ifdef PARITY_STATS_EN
        chk({name, "_ok_cnt"},  32'(bus.ok_cnt),  32'd0);
        chk({name, "_err_cnt"}, 32'(bus.err_cnt), 32'd0);
`endif
    endtask

    // -------------------------------------------------------------------------
    // Monitor: sample 1 time unit after each rising edge.
    // -------------------------------------------------------------------------
    always @(posedge clk) begin : mon
        rpt_t e;
        #1;
        if (rst_n) begin
            if (bus.frame_done) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_report: got frame_done=1 expected no report, len=%0d at %0t",
                             bus.frame_len, $time);
                end else begin
                    e = exp_q.pop_front();
                    $display("report: ok=%0b err=%0b len_err=%0b len=%0d (want ok=%0b len_err=%0b len=%0d)",
                             bus.parity_ok, bus.parity_err, bus.len_err, bus.frame_len,
                             e.ok, e.lerr, e.len);
                    chk("parity_ok",  32'(bus.parity_ok),  32'(e.ok));
                    chk("parity_err", 32'(bus.parity_err), 32'(!e.ok));
                    chk("len_err",    32'(bus.len_err),    32'(e.lerr));
                    chk("frame_len",  32'(bus.frame_len),  32'(e.len));
`ifdef PARITY_STATS_EN
                    if (e.ok && !e.lerr) begin
                        if (ok_exp < STAT_MAX) ok_exp++;
                    end else begin
                        if (err_exp < STAT_MAX) err_exp++;
                    end
                    chk("ok_cnt",  32'(bus.ok_cnt),  32'(ok_exp));
                    chk("err_cnt", 32'(bus.err_cnt), 32'(err_exp));
`endif
                end
            end else begin
                chk("quiet_outputs",
                    32'({bus.parity_ok, bus.parity_err, bus.len_err, bus.frame_len}), 32'd0);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        bus.valid   = 1'b0;
        bus.data_in = '0;
        bus.mode    = 1'b0;
        bus.abort   = 1'b0;
`ifdef PARITY_STATS_EN
        bus.stats_clr = 1'b0;
`endif

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset_state");
        @(negedge clk);
        rst_n = 1'b1;
        cyc(0, 8'h00, 0, 0);

        // Even frame pass: 0x03 ^ 0x05 -> parity 0, mode 0
        cyc(1, 8'h03, 0, 0);
        cyc(1, 8'h05, 0, 0);
        cyc(0, 8'h00, 0, 0); push(1, 0, 2);
        cyc(0, 8'h00, 0, 0);

        // Odd mode latched on first beat, toggled mid-frame: XOR = 1
        cyc(1, 8'h01, 1, 0);
        cyc(1, 8'h00, 0, 0);
        cyc(0, 8'h00, 0, 0); push(1, 0, 2);
        // Same beats starting in mode 0 -> parity error
        cyc(1, 8'h01, 0, 0);
        cyc(1, 8'h00, 1, 0);
        cyc(0, 8'h00, 0, 0); push(0, 0, 2);
        cyc(0, 8'h00, 0, 0);

        // Exactly MAX_BEATS: four ones, parity 0, no overflow
        repeat (4) cyc(1, 8'h01, 0, 0);
        cyc(0, 8'h00, 0, 0); push(1, 0, 4);
        // Overflow: six ones -> len saturates, len_err, parity 0
        repeat (6) cyc(1, 8'h01, 0, 0);
        cyc(0, 8'h00, 0, 0); push(1, 1, 4);
        // Five beats: overflow with odd parity under mode 0
        repeat (5) cyc(1, 8'h01, 0, 0);
        cyc(0, 8'h00, 0, 0); push(0, 1, 4);
        cyc(0, 8'h00, 0, 0);

        // One-beat frame, MSB only, odd mode
        cyc(1, 8'h80, 1, 0);
        cyc(0, 8'h00, 0, 0); push(1, 0, 1);

        // Back-to-back: report of the first overlaps the second's first beat
        cyc(1, 8'h07, 0, 0);
        cyc(0, 8'h00, 0, 0); push(0, 0, 1);
        cyc(1, 8'h0F, 0, 0);
        cyc(1, 8'h01, 0, 0);
        cyc(0, 8'h00, 0, 0); push(0, 0, 2);
        cyc(0, 8'h00, 0, 0);

        // Abort on the second beat, then a fresh frame 0x00
        cyc(1, 8'h01, 0, 0);
        cyc(1, 8'h02, 0, 1);
        cyc(1, 8'h00, 0, 0);
        cyc(0, 8'h00, 0, 0); push(1, 0, 1);
        cyc(0, 8'h00, 0, 0);

        // Abort together with valid=0 on the closing edge: no report
        cyc(1, 8'h01, 0, 0);
        cyc(0, 8'h00, 0, 1);
        cyc(0, 8'h00, 0, 0);

        // Abort in IDLE ignores valid
        cyc(1, 8'h01, 0, 1);
        cyc(0, 8'h00, 0, 0);
        cyc(0, 8'h00, 0, 0);

        // Asynchronous reset while a report is showing
        cyc(1, 8'h01, 1, 0);
        cyc(0, 8'h00, 0, 0); push(1, 0, 1);
        @(posedge clk);
        #2;
        rst_n   = 1'b0;
        ok_exp  = 0;
        err_exp = 0;
        #1;
        chk_all_zero("rst_async");
        cyc(0, 8'h00, 0, 0);
        rst_n = 1'b1;

        // Reset mid-frame: the frame must vanish without a report
        cyc(1, 8'h01, 0, 0);
        cyc(1, 8'h02, 0, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_midframe");
        cyc(0, 8'h00, 0, 0);
        rst_n = 1'b1;
        repeat (3) cyc(0, 8'h00, 0, 0);

`ifdef PARITY_STATS_EN
        // Five passing frames saturate ok_cnt at 3
        repeat (5) begin
            cyc(1, 8'h00, 0, 0);
            cyc(0, 8'h00, 0, 0); push(1, 0, 1);
        end
        cyc(0, 8'h00, 0, 0);
        chk("ok_cnt_sat", 32'(bus.ok_cnt), 32'(STAT_MAX));
        // One failing frame bumps err_cnt
        cyc(1, 8'h01, 0, 0);
        cyc(0, 8'h00, 0, 0); push(0, 0, 1);
        cyc(0, 8'h00, 0, 0);
        chk("err_cnt_one", 32'(bus.err_cnt), 32'd1);
        // Clear pulse
        @(negedge clk);
        bus.stats_clr = 1'b1;
        @(negedge clk);
        bus.stats_clr = 1'b0;
        ok_exp  = 0;
        err_exp = 0;
        chk("ok_cnt_clr",  32'(bus.ok_cnt),  32'd0);
        chk("err_cnt_clr", 32'(bus.err_cnt), 32'd0);
`endif

        repeat (3) cyc(0, 8'h00, 0, 0);
        chk("pending_reports", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_parity_frame_chk
